square_collide: RTL

//  Reader side of the square_unit output bus. Once per frame it walks NUM_SQ

---
 rtl/square_collide_if.sv | 32 +++
 rtl/square_collide.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/square_collide_if.sv
// Square-scan bus between the collision reader and its environment.
// Carries the square select mux, the selected square's centre and depth,
// cruiser position, the frame tick and the collision/lives status.
// Ports:
//   master : the reader (square_collide). It drives sq_sel and the status outputs.
//   slave  : the environment. It drives frame_tick, square data and cruiser position.
interface square_collide_if;
  logic       frame_tick;
  logic [8:0] sq_x;
  logic [8:0] sq_y;
  logic [5:0] sq_depth;
  logic [8:0] cr_x;
  logic [8:0] cr_y;
  logic [3:0] sq_sel;
  logic       busy;
  logic       hit;
  logic [3:0] hit_idx;
  logic [2:0] lives;
  logic       invuln;
  logic       game_over;
  logic       overrun;

  modport master (
    input  frame_tick, sq_x, sq_y, sq_depth, cr_x, cr_y,
    output sq_sel, busy, hit, hit_idx, lives, invuln, game_over, overrun
  );

  modport slave (
    output frame_tick, sq_x, sq_y, sq_depth, cr_x, cr_y,
    input  sq_sel, busy, hit, hit_idx, lives, invuln, game_over, overrun
  );
endinterface

// File: rtl/square_collide.sv
// Purpose: per-frame scan of NUM_SQ squares for cruiser collisions; tracks lives/game_over.
// Latency: scan takes 2*NUM_SQ cycles; hit pulses one cycle after the square's check cycle.
// Backpressure: none; a frame_tick during a scan is dropped and flagged on overrun.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   bus (master) : frame_tick, sq_x/sq_y/sq_depth, cr_x/cr_y in;
//                  sq_sel, busy, hit, hit_idx, lives, invuln, game_over, overrun out
module square_collide #(
  parameter int NUM_SQ      = 8,
  parameter int HIT_DEPTH   = 4,
  parameter int REARM_DEPTH = 32,
  parameter int CR_HALF     = 12,
  parameter int LIVES       = 3,
  parameter int INVULN      = 30
) (
  input  logic             clock,
  input  logic             reset,
  square_collide_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    CHK  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_SQ - 1);

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic        start;

  // Sized for the maximum of 16 squares so the 4-bit index never runs off the end.
  logic [15:0] armed;
  logic        scan_hit;
  logic        hit_r;
  logic [3:0]  hit_idx_r;
  logic [2:0]  lives_r;
  logic        invuln_r;
  logic        game_over_r;
  logic        overrun_r;
  logic [7:0]  inv_cnt;

  logic [5:0]  inv_depth;
  logic [9:0]  h, lim, dx, dy;
  logic        near, overlap, candidate, accept, rearm;

  // ---------------- scan FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_tick && !game_over_r) begin
          state_nxt = SEL;
          idx_nxt   = 4'd0;
          start     = 1'b1;
        end
      end
      // One cycle for the external mux to settle on the new select.
      SEL: state_nxt = CHK;
      CHK: begin
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
          idx_nxt   = 4'd0;
        end else begin
          state_nxt = SEL;
          idx_nxt   = idx + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 4'd0;
      end
    endcase
  end

  // ---------------- overlap test ----------------
  // Apparent half-size grows as the square approaches (depth 0 -> h = 31).
  assign inv_depth = 6'd63 - bus.sq_depth;
  assign h         = 10'(inv_depth) >> 1;
  assign lim       = h + 10'(CR_HALF);
  assign dx        = (bus.sq_x >= bus.cr_x) ? 10'(bus.sq_x - bus.cr_x) : 10'(bus.cr_x - bus.sq_x);
  assign dy        = (bus.sq_y >= bus.cr_y) ? 10'(bus.sq_y - bus.cr_y) : 10'(bus.cr_y - bus.sq_y);
  assign overlap   = (dx <= lim) && (dy <= lim);
  assign near      = bus.sq_depth <= 6'(HIT_DEPTH);

  assign candidate = (state == CHK) && armed[idx] && near && overlap;
  // scan_hit keeps later candidates from counting even if INVULN is zero.
  assign accept    = candidate && !invuln_r && !game_over_r && !scan_hit;
  assign rearm     = (state == CHK) && !armed[idx] && (bus.sq_depth >= 6'(REARM_DEPTH));

  // ---------------- collision / lives state ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed       <= '1;
      scan_hit    <= 1'b0;
      hit_r       <= 1'b0;
      hit_idx_r   <= 4'd0;
      lives_r     <= 3'(LIVES);
      invuln_r    <= 1'b0;
      game_over_r <= 1'b0;
      overrun_r   <= 1'b0;
      inv_cnt     <= 8'd0;
    end else begin
      hit_r     <= accept;
      overrun_r <= bus.frame_tick && (state != IDLE) && !game_over_r;

      if (start)       scan_hit <= 1'b0;
      else if (accept) scan_hit <= 1'b1;

      // A candidate always consumes the square, even when no life is lost.
      if (candidate)  armed[idx] <= 1'b0;
      else if (rearm) armed[idx] <= 1'b1;

      if (accept) begin
        hit_idx_r <= idx;
        if (lives_r != 3'd0) lives_r <= lives_r - 3'd1;
        if (lives_r <= 3'd1) game_over_r <= 1'b1;
      end

      // A fresh hit reloads the window; otherwise every tick (even dropped ones) counts down.
      if (accept) begin
        invuln_r <= 1'b1;
        inv_cnt  <= 8'(INVULN);
      end else if (bus.frame_tick && invuln_r) begin
        if (inv_cnt <= 8'd1) begin
          inv_cnt  <= 8'd0;
          invuln_r <= 1'b0;
        end else begin
          inv_cnt  <= inv_cnt - 8'd1;
        end
      end
    end
  end

  assign bus.sq_sel    = idx;
  assign bus.busy      = (state != IDLE);
  assign bus.hit       = hit_r;
  assign bus.hit_idx   = hit_idx_r;
  assign bus.lives     = lives_r;
  assign bus.invuln    = invuln_r;
  assign bus.game_over = game_over_r;
  assign bus.overrun   = overrun_r;

endmodule
